imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory load sequencer for the PAT core. Accepts a byte stream from an external host over a valid/ready handshake and packs every six bytes into one `i_buffer_size × i_width`-bit instruction word. It writes each word into the instruction buffer at incrementing addresses, and holds the PAT in reset for the whole load. It sits between the pad/host interface and the instruction buffer's `imem_write_adr`/`imem_write`/`imem_in` port, in the `digital` top level.

## Interface
- `d_width`, 8, byte width of the host stream.
- `i_adr_width`, 10, instruction address width.
- `i_width`, 23, instruction width.
- `i_buffer_size`, 2, instructions per write word; word width W = 46.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `load_base`  in  i_adr_width  instruction address of the first word; sampled with `load_start`.
- `load_words`  in  i_adr_width  number of W-bit words to load; sampled with `load_start`.
- `abort`  in  1  cancels a load in progress.
- `byte_in`  in  d_width  host data byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts `byte_in` this cycle.
- `imem_write_adr`  out  i_adr_width  write address to the instruction buffer.
- `imem_write`  out  1  one-cycle write strobe.
- `imem_in`  out  W  packed word (instruction 0 in bits [22:0], instruction 1 in bits [45:23]).
- `pat_reset`  out  1  reset to PAT and instruction buffer.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the load completes.
- `aborted`  out  1  one-cycle pulse when a load is cancelled.

## Operation
- States: IDLE, COLLECT, WRITE, FINISH.
- **IDLE**
  - `load_start` with `load_words`≠0: latch base and count, clear byte index, go to COLLECT.
  - `load_start` with `load_words`=0: pulse `done` next cycle and stay in IDLE.
  - `abort` is ignored.
- **COLLECT**
  - `byte_ready` = 1 & ~`abort`.
  - Each accepted byte k (k = 0..5) is stored in assembly bits [8k+7:8k]. Ordering is little-endian, and bits [47:46] of byte 5 are discarded.
  - After byte 5 is accepted, go to WRITE.
- **WRITE**
  - `imem_write` = 1, `imem_write_adr` = current address, `imem_in` = assembly[45:0], `byte_ready` = 0.
  - Next cycle: address += i_buffer_size (mod 2^i_adr_width, wraps silently) and remaining -= 1.
  - If remaining reaches 0, go to FINISH; otherwise go to COLLECT with the byte index cleared.
- **FINISH**: `done` = 1 for one cycle, then go to IDLE.
- **`abort`**
  - Acts in COLLECT only: go to IDLE, pulse `aborted`, and do not write the partial word.
  - A byte presented in the same cycle is not accepted.
  - `abort` during WRITE or FINISH is ignored; that write completes.
- `load_start` outside IDLE is ignored.
- `busy` = (state ≠ IDLE).
- `pat_reset` = `reset` | (state ≠ IDLE). This is combinational from the state register and the reset input only.

## Timing
- **Reset values**
  - State IDLE, address 0, remaining 0.
  - `imem_write` 0, `imem_in` 0, `imem_write_adr` 0.
  - `byte_ready` 0, `busy` 0, `done` 0, `aborted` 0.
  - `pat_reset` 1 while `reset` is high, 0 afterwards.
- **Load start latency**: `load_start` at cycle T gives `busy` and `byte_ready` high at T+1.
- **Write latency**: 6th byte accepted at cycle N gives `imem_write` high at N+1 only; `byte_ready` returns at N+2.
- **Last word**: `done` at N+2, `busy` and `pat_reset` low at N+3.
- **Throughput**: 7 cycles per word minimum. `byte_valid` gaps stall COLLECT indefinitely.
- **Handshake**: a byte transfers on any edge where `byte_valid` & `byte_ready`. `byte_in` is don't-care otherwise.
- **Reset mid-load**: returns to IDLE the following cycle. No further writes occur, the partial word is lost, and neither `done` nor `aborted` pulses.
- **Output stability**: `imem_in` and `imem_write_adr` hold their values after WRITE until the next WRITE.

## Test plan
- **Single word**: reset, then `load_start` with base=0x010 and words=1, then bytes 0x11,0x22,0x33,0x44,0x55,0xFF. Expect one `imem_write` with adr=0x010 and `imem_in`=46'h3F_5544_3322_11 (bits [47:46] dropped), then `done` 2 cycles after the 6th byte, then `pat_reset` low.
- **Three words at full rate**: base=0x000, words=3. Expect addresses 0x000, 0x002, 0x004, writes spaced 7 cycles apart, `pat_reset` high throughout and low after `done`.
- **Wrap-around**: base=0x3FE, words=2. Expect writes at 0x3FE then 0x000.
- **Zero words**: `load_start` with words=0. Expect `done` next cycle, `busy` never asserted, no `imem_write`.
- **Abort**: abort after byte 3 with `byte_valid` high in the same cycle. Expect the byte not accepted, `aborted` pulse, no `imem_write`, IDLE; a following load then behaves normally.
- **Reset mid-load and ignored start**: `reset` mid-COLLECT gives all outputs at reset values and no write. Random `byte_valid` gaps give correct packing. `load_start` while busy is ignored.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: instruction-memory load sequencer for the PAT core.
// Packs a host byte stream (little-endian, six bytes per word) into
// i_buffer_size*i_width-bit words and writes them into the instruction
// buffer at incrementing addresses. The PAT is held in reset for the whole load.
module imem_loader #(
  parameter int d_width       = 8,
  parameter int i_adr_width   = 10,
  parameter int i_width       = 23,
  parameter int i_buffer_size = 2,
  localparam int W            = i_buffer_size * i_width
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic [i_adr_width-1:0] load_base,
  input  logic [i_adr_width-1:0] load_words,
  input  logic                   abort,
  input  logic [d_width-1:0]     byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [i_adr_width-1:0] imem_write_adr,
  output logic                   imem_write,
  output logic [W-1:0]           imem_in,
  output logic                   pat_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  // Bytes per word; the top bits of the last byte beyond W are dropped.
  localparam int BYTES = (W + d_width - 1) / d_width;
  localparam int IDXW  = $clog2(BYTES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  localparam logic [i_adr_width-1:0] ADR_STEP = i_adr_width'(i_buffer_size);

  logic [1:0]             state;
  logic [i_adr_width-1:0] addr;
  logic [i_adr_width-1:0] remaining;
  logic [IDXW-1:0]        idx;
  logic [W-1:0]           pack;     // word under assembly
  logic [W-1:0]           word_q;   // last written word, held between writes
  logic [i_adr_width-1:0] adr_q;    // last written address, held between writes
  logic                   zdone;    // done pulse for a zero-length load
  logic                   aborted_q;

  // Sequencer state, address/count tracking and byte assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      idx       <= '0;
      pack      <= '0;
      word_q    <= '0;
      adr_q     <= '0;
      zdone     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      zdone     <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            if (load_words != '0) begin
              addr      <= load_base;
              remaining <= load_words;
              idx       <= '0;
              state     <= COLLECT;
            end else begin
              zdone <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (abort) begin
            state     <= IDLE;
            aborted_q <= 1'b1;
          end else if (byte_valid) begin
            // Byte idx lands at bits [8*idx+7 : 8*idx]; bits past W fall off.
            for (int b = 0; b < W; b++) begin
              if (IDXW'(b / d_width) == idx) pack[b] <= byte_in[b % d_width];
            end
            idx <= idx + 1'b1;
            if (idx == IDXW'(BYTES - 1)) state <= WRITE;
          end
        end
        WRITE: begin
          word_q    <= pack;
          adr_q     <= addr;
          addr      <= addr + ADR_STEP;
          remaining <= remaining - 1'b1;
          idx       <= '0;
          state     <= (remaining == i_adr_width'(1)) ? FINISH : COLLECT;
        end
        default: state <= IDLE;  // FINISH
      endcase
    end
  end

  // Outputs decoded from state; write port shows live data during WRITE,
  // otherwise the last written values so they stay stable.
  always_comb begin
    busy           = (state != IDLE);
    pat_reset      = reset | (state != IDLE);
    byte_ready     = (state == COLLECT) & ~abort;
    imem_write     = (state == WRITE);
    imem_in        = imem_write ? pack : word_q;
    imem_write_adr = imem_write ? addr : adr_q;
    done           = (state == FINISH) | zdone;
    aborted        = aborted_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed timing checks plus randomized
// loads compared against a byte-queue reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [9:0]  load_base;
  logic [9:0]  load_words;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [9:0]  imem_write_adr;
  logic        imem_write;
  logic [45:0] imem_in;
  logic        pat_reset;
  logic        busy;
  logic        done;
  logic        aborted;

  imem_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .load_words(load_words), .abort(abort), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_write_adr(imem_write_adr), .imem_write(imem_write), .imem_in(imem_in),
    .pat_reset(pat_reset), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: log every write and pulse seen on the DUT outputs.
  logic [9:0]  wr_adr[$];
  logic [45:0] wr_dat[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          abort_cnt = 0;
  int          wr_nopat = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_write) begin
        wr_adr.push_back(imem_write_adr);
        wr_dat.push_back(imem_in);
        wr_cyc.push_back(cyc);
        if (!pat_reset || !busy) wr_nopat++;
      end
      if (done)    done_cnt++;
      if (aborted) abort_cnt++;
    end
  end

  // Driver state
  logic [7:0] sent[$];
  bit         poke = 0;
  int         gap_pct = 0;

  task automatic start(input logic [9:0] base, input logic [9:0] words);
    load_start = 1'b1; load_base = base; load_words = words;
    @(negedge clk);
    load_start = 1'b0; load_base = 10'($urandom); load_words = 10'($urandom);
  endtask

  // Offer one byte until accepted, then an optional random idle gap.
  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    bit  rdy;
    byte_valid = 1'b1; byte_in = b;
    if (poke) begin
      load_start = 1'b1; load_base = 10'($urandom); load_words = 10'($urandom);
    end
    forever begin
      #1 rdy = byte_ready;
      @(negedge clk);
      load_start = 1'b0; poke = 0;
      if (rdy) break;
      n++;
      if (n > 50) begin chk("byte_stall", 0, 1); break; end
    end
    sent.push_back(b);
    byte_valid = 1'b0; byte_in = 8'($urandom);
    while ($urandom_range(99) < gap_pct) @(negedge clk);
  endtask

  task automatic run_load(input logic [9:0] base, input int words, input int gap, input bit do_poke);
    int w0 = wr_adr.size();
    int d0 = done_cnt;
    int n = 0;
    logic [47:0] full;
    logic [9:0]  eadr;
    sent.delete();
    start(base, 10'(words));
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < words * 6; i++) begin
      gap_pct = (i == words * 6 - 1) ? 0 : gap;
      if (do_poke && i == 2) poke = 1;
      send_byte(8'($urandom));
    end
    while (!done && n < 10) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("pat_low_after_done", pat_reset, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("n_writes", wr_adr.size() - w0, words);
    for (int i = 0; i < words && (w0 + i) < wr_adr.size(); i++) begin
      for (int k = 0; k < 6; k++) full[8*k +: 8] = sent[6*i + k];
      eadr = base + 10'(2 * i);
      chk("wr_adr", wr_adr[w0 + i], eadr);
      chk("wr_data", wr_dat[w0 + i], full[45:0]);
      if (gap == 0 && i > 0) chk("wr_spacing", wr_cyc[w0 + i] - wr_cyc[w0 + i - 1], 7);
    end
  endtask

  initial begin
    int w0, d0, a0;
    logic [7:0] bytes1 [6];
    reset = 1'b1; load_start = 1'b0; load_base = '0; load_words = '0;
    abort = 1'b0; byte_in = '0; byte_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_pat_reset", pat_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write", imem_write, 0);
    chk("rst_imem_in", imem_in, 0);
    chk("rst_adr", imem_write_adr, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("pat_after_rst", pat_reset, 0);

    // Single word, directed bytes and exact timing
    bytes1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
    gap_pct = 0;
    start(10'h010, 10'd1);
    chk("sw_busy", busy, 1);
    chk("sw_ready", byte_ready, 1);
    for (int i = 0; i < 6; i++) send_byte(bytes1[i]);
    chk("sw_write", imem_write, 1);
    chk("sw_adr", imem_write_adr, 10'h010);
    chk("sw_data", imem_in, 46'h3F_5544_3322_11);
    chk("sw_ready_in_write", byte_ready, 0);
    @(negedge clk);
    chk("sw_done", done, 1);
    chk("sw_write_once", imem_write, 0);
    chk("sw_pat_busy", pat_reset, 1);
    @(negedge clk);
    chk("sw_idle", busy, 0);
    chk("sw_pat_low", pat_reset, 0);
    chk("sw_done_pulse", done, 0);
    chk("sw_hold_data", imem_in, 46'h3F_5544_3322_11);
    chk("sw_hold_adr", imem_write_adr, 10'h010);

    // Three words at full rate, then wrap-around
    run_load(10'h000, 3, 0, 0);
    run_load(10'h3FE, 2, 0, 0);

    // Zero words
    w0 = wr_adr.size();
    start(10'h123, 10'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_no_write", wr_adr.size() - w0, 0);

    // Abort ignored in IDLE
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", abort_cnt, 0);

    // Abort after three bytes with a byte offered in the same cycle
    w0 = wr_adr.size();
    gap_pct = 0;
    start(10'h200, 10'd2);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    byte_valid = 1'b1; byte_in = 8'hAA; abort = 1'b1;
    #1 chk("abort_not_ready", byte_ready, 0);
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_idle", busy, 0);
    @(negedge clk);
    chk("abort_pulse_once", aborted, 0);
    chk("abort_count", abort_cnt, 1);
    chk("abort_no_write", wr_adr.size() - w0, 0);
    run_load(10'h100, 2, 20, 0);

    // Reset mid-load
    w0 = wr_adr.size(); d0 = done_cnt; a0 = abort_cnt;
    start(10'h055, 10'd3);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_write", imem_write, 0);
    chk("mid_rst_imem_in", imem_in, 0);
    chk("mid_rst_adr", imem_write_adr, 0);
    chk("mid_rst_pat", pat_reset, 1);
    chk("mid_rst_ready", byte_ready, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_pat_low", pat_reset, 0);
    chk("mid_rst_no_write", wr_adr.size() - w0, 0);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_abort", abort_cnt - a0, 0);

    // Random loads with byte_valid gaps and stray load_start while busy
    for (int t = 0; t < 8; t++)
      run_load(10'($urandom), $urandom_range(1, 4), 35, t[0]);

    chk("pat_high_at_writes", wr_nopat, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
